mux2_arbiter: RTL and testbench
===============================

# mux2_arbiter

Round-robin controller that shares the `mux2_1` datapath between two requesters. It owns the mux `sel` line and issues grants. It forwards the selected requester's data to a single downstream consumer over a valid/ready handshake. Grants are held for a whole burst, terminated by `last`, with a cycle cap so that neither source can starve the other.

## Interface
- `DATA_W`, 8, width of each data input and of `out_data`.
- `MAX_HOLD`, 16, maximum cycles one grant may be held. Legal range 2..255.

- `sys_clk`  in  1  system clock; all state updates on its rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `req1`  in  1  requester 1 has a valid beat on `in1`.
- `in1`  in  DATA_W  requester 1 data; the mux path taken when `sel`=1.
- `last1`  in  1  current `in1` beat is the final beat of the burst.
- `gnt1`  out  1  requester 1 owns the mux.
- `req2`, `in2`, `last2`, `gnt2`  same as above, for requester 2; the mux path taken when `sel`=0.
- `sel`  out  1  mux select; registered.
- `out_valid`  out  1  downstream beat valid.
- `out_data`  out  DATA_W  downstream data, equal to `sel ? in1 : in2`.
- `out_ready`  in  1  downstream accepts the beat.
- `hold_expire`  out  1  one-cycle pulse when a grant is revoked by the `MAX_HOLD` cap.

## Operation
- FSM states: IDLE, SERVE1, SERVE2. State, `sel`, priority pointer `prio`, and hold counter `hold_cnt` are all registered.
- `gnt1` = (state==SERVE1). `gnt2` = (state==SERVE2).
- `out_valid` = (SERVE1 & `req1`) | (SERVE2 & `req2`). It is 0 in IDLE.
- Accepted beat: `out_valid` & `out_ready` in the same cycle.
- `prio` selects the winner when both requests are asserted in IDLE. `prio`=1 after reset. Each release flips `prio` to the other requester.
- IDLE → SERVEx when `reqx` is asserted. If both are asserted, the winner is given by `prio`. `sel` is loaded on the same edge: 1 for SERVE1, 0 for SERVE2.
- Release condition in SERVEx, evaluated every cycle. Any one of the following releases the grant:
  - an accepted beat with `lastx`=1;
  - `reqx`=0, meaning the requester withdrew;
  - `hold_cnt`==MAX_HOLD-1, the cap.
- Next state on release:
  - SERVEother if the other requester's req is 1 (no idle bubble);
  - otherwise SERVEx again if `reqx` is still 1, with a fresh grant and `hold_cnt` cleared;
  - otherwise IDLE.
- `hold_cnt` clears to 0 on every entry to a SERVE state. It increments every cycle spent in SERVE. Width is 8 bits, and it never wraps because the cap always releases first.
- `hold_expire` is pulsed for 1 cycle, registered, in the cycle after a cap release. It does not fire if a `last` beat was accepted in that same cycle; the `last` release takes precedence.
- `sel` holds its last value in IDLE.

## Timing
- Reset values: state=IDLE, `sel`=1, `prio`=1, `hold_cnt`=0, `gnt1`=`gnt2`=0, `out_valid`=0, `hold_expire`=0. `out_data` equals `in1` while `sel`=1.
- Grant latency: a req seen in IDLE at edge N gives gnt=1 and the updated `sel` during cycle N+1.
- Data path is combinational from inputs to `out_data`/`out_valid` (zero cycles). Backpressure passes through: `out_ready`=0 stalls without consuming the grant, but `hold_cnt` keeps counting.
- Handover without a bubble: a `last1` beat accepted in cycle N with `req2`=1 gives SERVE2, `gnt2`=1 and `sel`=0 in cycle N+1.
- Maximum continuous grant is MAX_HOLD cycles.
- Asserting `sys_rst_n` low mid-burst forces all reset values immediately, independent of the clock. The in-flight burst is abandoned with no recovery.

## Test plan
- **Single requester:** after reset, `req1`=1 with a 3-beat burst, `out_ready`=1, `last1` on beat 3. Expected:
  - `gnt1` in cycle 1;
  - `out_data`=`in1` for 3 accepted beats;
  - IDLE after the `last1` beat, with `sel` held at 1.
- **Simultaneous requests:** `req1`=`req2`=1 from reset, 2-beat bursts each. Expected: SERVE1 first, then SERVE2 with no bubble, then SERVE1 again. `sel` sequence 1,1,0,0,1; `prio` alternates.
- **Cap enforcement:** MAX_HOLD=4, `req2` held continuously with no `last2`, `req1`=1. Expected:
  - `gnt2` for exactly 4 cycles;
  - `hold_expire` pulses once;
  - then `gnt1`, `sel`=1.
- **Backpressure:** SERVE1, `out_ready`=0 for 2 cycles, then 1. Expected: `out_valid`=1 throughout, no beat consumed during the stall, `hold_cnt` advances by 2.
- **Withdrawal and reset:**
  - `req1` drops mid-burst → IDLE next cycle.
  - A separate run pulls `sys_rst_n` low for 1 ns mid-SERVE2. Expected: `gnt2`=0, `sel`=1 and `out_valid`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mux2_arbiter.sv
// Round-robin owner of the mux2_1 select line. Grants one of two requesters
// for a burst (ended by last, withdrawal or a hold cap) and forwards the
// selected data to a single valid/ready consumer.
module mux2_arbiter #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              req1,
    input  logic [DATA_W-1:0] in1,
    input  logic              last1,
    output logic              gnt1,
    input  logic              req2,
    input  logic [DATA_W-1:0] in2,
    input  logic              last2,
    output logic              gnt2,
    output logic              sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              hold_expire
);

    typedef enum logic [1:0] {StIdle, StServe1, StServe2} state_e;

    // Last count value of a grant; reaching it forces a release.
    localparam logic [7:0] CapCnt = 8'(MAX_HOLD - 1);

    state_e      state_q, state_d;
    logic        sel_q, sel_d;
    logic        prio_q, prio_d;        // 1: requester 1 wins a tie in idle
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        hold_expire_q, hold_expire_d;

    logic        serving1;
    logic        own_req, own_last, oth_req;
    logic        last_acc, cap_hit, release_grant;

    assign gnt1        = (state_q == StServe1);
    assign gnt2        = (state_q == StServe2);
    assign sel         = sel_q;
    assign hold_expire = hold_expire_q;
    assign out_valid   = (gnt1 & req1) | (gnt2 & req2);
    assign out_data    = sel_q ? in1 : in2;

    // Signals of the current owner vs the waiting requester (only meaningful in SERVE).
    assign serving1      = (state_q == StServe1);
    assign own_req       = serving1 ? req1  : req2;
    assign own_last      = serving1 ? last1 : last2;
    assign oth_req       = serving1 ? req2  : req1;
    assign last_acc      = out_valid & out_ready & own_last;
    assign cap_hit       = (hold_cnt_q == CapCnt);
    assign release_grant = last_acc | ~own_req | cap_hit;

    // Next-state: arbitration in idle, release/handover while serving.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        prio_d        = prio_q;
        hold_cnt_d    = hold_cnt_q;
        hold_expire_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req1 && (prio_q || !req2)) begin
                    state_d    = StServe1;
                    sel_d      = 1'b1;
                    hold_cnt_d = 8'd0;
                end else if (req2) begin
                    state_d    = StServe2;
                    sel_d      = 1'b0;
                    hold_cnt_d = 8'd0;
                end
            end
            StServe1, StServe2: begin
                if (release_grant) begin
                    // A last beat in the cap cycle counts as a normal finish.
                    hold_expire_d = cap_hit & ~last_acc;
                    prio_d        = ~serving1;
                    hold_cnt_d    = 8'd0;
                    if (oth_req) begin
                        state_d = serving1 ? StServe2 : StServe1;
                        sel_d   = ~serving1;
                    end else if (!own_req) begin
                        state_d = StIdle;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= StIdle;
            sel_q         <= 1'b1;
            prio_q        <= 1'b1;
            hold_cnt_q    <= 8'd0;
            hold_expire_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            prio_q        <= prio_d;
            hold_cnt_q    <= hold_cnt_d;
            hold_expire_q <= hold_expire_d;
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: directed vector table, async reset
// sequence, then random traffic against a behavioural ownership model.
module tb_mux2_arbiter;

    localparam int DW   = 8;
    localparam int HOLD = 4;

    logic          sys_clk, sys_rst_n;
    logic          req1, last1, req2, last2, out_ready;
    logic [DW-1:0] in1, in2;
    logic          gnt1, gnt2, sel, out_valid, hold_expire;
    logic [DW-1:0] out_data;

    mux2_arbiter #(.DATA_W(DW), .MAX_HOLD(HOLD)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .req1        (req1),
        .in1         (in1),
        .last1       (last1),
        .gnt1        (gnt1),
        .req2        (req2),
        .in2         (in2),
        .last2       (last2),
        .gnt2        (gnt2),
        .sel         (sel),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .hold_expire (hold_expire)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_err    = 0;

    // Packed view: {gnt1, gnt2, sel, out_valid, hold_expire, out_data}
    function automatic logic [12:0] dut_out();
        return {gnt1, gnt2, sel, out_valid, hold_expire, out_data};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got g1g2 sel vld exp=%b data=%h, expected %b data=%h",
                     name, act[12:8], act[7:0], exp[12:8], exp[7:0]);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_owner;   // 0 none, 1 or 2 = requester currently granted
    int m_held;    // cycles already spent in the current grant
    bit m_prio;    // 1: requester 1 wins a tie
    bit m_sel;
    bit m_exp;

    task automatic model_reset();
        m_owner = 0; m_held = 0; m_prio = 1'b1; m_sel = 1'b1; m_exp = 1'b0;
    endtask

    function automatic logic [12:0] model_out();
        logic v;
        v = (m_owner == 1 && req1) || (m_owner == 2 && req2);
        return {m_owner == 1, m_owner == 2, m_sel, v, m_exp, m_sel ? in1 : in2};
    endfunction

    task automatic model_step();
        bit my_req, my_last, oth, took_last, at_cap;
        int other;
        if (m_owner == 0) begin
            m_exp = 1'b0;
            if (req1 && req2) m_owner = m_prio ? 1 : 2;
            else if (req1)    m_owner = 1;
            else if (req2)    m_owner = 2;
            if (m_owner != 0) begin
                m_held = 0;
                m_sel  = (m_owner == 1);
            end
        end else begin
            other     = 3 - m_owner;
            my_req    = (m_owner == 1) ? req1  : req2;
            my_last   = (m_owner == 1) ? last1 : last2;
            oth       = (m_owner == 1) ? req2  : req1;
            took_last = my_req && out_ready && my_last;
            at_cap    = (m_held == HOLD - 1);
            if (took_last || !my_req || at_cap) begin
                m_exp  = at_cap && !took_last;
                m_prio = (other == 1);
                if (oth)          m_owner = other;
                else if (!my_req) m_owner = 0;
                m_held = 0;
                if (m_owner != 0) m_sel = (m_owner == 1);
            end else begin
                m_held++;
                m_exp = 1'b0;
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic r1, l1, r2, l2, rdy;      // inputs
        logic g1, g2, s, vld, ex;       // expected outputs
    } vec_t;

    function automatic vec_t mk(input logic [4:0] i, input logic [4:0] e);
        return vec_t'({i, e});
    endfunction

    vec_t vecs[22];

    initial begin
        logic [12:0] e;
        // inputs: req1 last1 req2 last2 ready | expected: gnt1 gnt2 sel valid expire
        vecs[0]  = mk(5'b10101, 5'b00100);  // idle, tie -> prio gives 1
        vecs[1]  = mk(5'b10101, 5'b10110);
        vecs[2]  = mk(5'b11101, 5'b10110);  // last1 accepted, req2 waiting
        vecs[3]  = mk(5'b10101, 5'b01010);  // handover without bubble
        vecs[4]  = mk(5'b10111, 5'b01010);  // last2 -> back to 1
        vecs[5]  = mk(5'b11001, 5'b10110);  // last1, req1 still up -> fresh grant
        vecs[6]  = mk(5'b00001, 5'b10100);  // withdraw -> idle
        vecs[7]  = mk(5'b00100, 5'b00100);  // idle, req2 only, stalled sink
        vecs[8]  = mk(5'b10100, 5'b01010);  // hold 0, backpressure
        vecs[9]  = mk(5'b10101, 5'b01010);
        vecs[10] = mk(5'b10101, 5'b01010);
        vecs[11] = mk(5'b10101, 5'b01010);  // cap cycle
        vecs[12] = mk(5'b10001, 5'b10111);  // gnt1 + expire pulse
        vecs[13] = mk(5'b11001, 5'b10110);
        vecs[14] = mk(5'b00001, 5'b10100);
        vecs[15] = mk(5'b00101, 5'b00100);
        vecs[16] = mk(5'b00101, 5'b01010);
        vecs[17] = mk(5'b00101, 5'b01010);
        vecs[18] = mk(5'b00101, 5'b01010);
        vecs[19] = mk(5'b00111, 5'b01010);  // last2 in cap cycle
        vecs[20] = mk(5'b00001, 5'b01000);  // no expire pulse, withdraw
        vecs[21] = mk(5'b00001, 5'b00000);  // idle, sel held at 0

        sys_rst_n = 1'b0;
        {req1, last1, req2, last2, out_ready} = '0;
        in1 = 8'hA5;
        in2 = 8'h5A;
        #7;
        check("reset", dut_out(), {5'b00100, 8'hA5});
        #5 sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        for (int i = 0; i < 22; i++) begin
            {req1, last1, req2, last2, out_ready} =
                {vecs[i].r1, vecs[i].l1, vecs[i].r2, vecs[i].l2, vecs[i].rdy};
            in1 = DW'($urandom);
            in2 = DW'($urandom);
            @(negedge sys_clk);
            e = {vecs[i].g1, vecs[i].g2, vecs[i].s, vecs[i].vld, vecs[i].ex,
                 vecs[i].s ? in1 : in2};
            check($sformatf("vec%0d", i), dut_out(), e);
            @(posedge sys_clk); #1;
        end

        // Async reset mid-SERVE2: state is idle with sel=0; grant requester 2.
        {req1, last1, req2, last2, out_ready} = 5'b00101;
        @(posedge sys_clk); #1;
        check("serve2_before_rst", dut_out(), {5'b01010, in2});
        #1 sys_rst_n = 1'b0;
        #1;
        check("async_rst", dut_out(), {5'b00100, in1});
        sys_rst_n = 1'b1;
        {req1, last1, req2, last2, out_ready} = '0;
        @(posedge sys_clk); #1;
        check("after_rst_idle", dut_out(), {5'b00100, in1});
        model_reset();

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            req1      = ($urandom_range(0, 3) != 0);
            req2      = ($urandom_range(0, 3) != 0);
            last1     = ($urandom_range(0, 2) == 0);
            last2     = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in1       = DW'($urandom);
            in2       = DW'($urandom);
            @(negedge sys_clk);
            check($sformatf("rand%0d", c), dut_out(), model_out());
            model_step();
            @(posedge sys_clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
